// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared types and table geometry for the decode-side branch predictor
package branch_predictor_pkg;
  localparam int NR_BHT_ENTRIES = 512;
  localparam int NR_BTB_ENTRIES = 64;
  localparam int NR_RAS_ENTRIES = 8;
  localparam int BHT_IDX_W = $clog2(NR_BHT_ENTRIES);
  localparam int BTB_IDX_W = $clog2(NR_BTB_ENTRIES);
  localparam int BTB_TAG_W = 64 - BTB_IDX_W - 2;
  localparam int ID_W = 6;
  localparam int BQ_ID_W = 4;
  typedef logic [ID_W-1:0] id_t;
  typedef enum logic [2:0] {OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU} ctrl_set_t;
  typedef struct packed {
    logic        taken;
    logic [63:0] pcnext;
  } bp_t;
  typedef logic [1:0] bht_ctr_t;
  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [63:0]          target;
  } btb_entry_t;
  function automatic logic is_bxx(input ctrl_set_t op);
    return op != OP_JAL && op != OP_JALR;
  endfunction
  function automatic logic is_link(input logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction
endpackage

// File: rtl/bq_push_if.sv
// bq_push_if: push channel from the predictor into the branch queue
interface bq_push_if;
  import branch_predictor_pkg::*;
  logic               valid;
  logic               ready;
  bp_t                bp;
  logic [63:0]        pc;
  id_t                id;
  logic [BQ_ID_W-1:0] bqid;
  modport master(output valid, bp, pc, id, input ready, bqid);
  modport slave(input valid, bp, pc, id, output ready, bqid);
endinterface

// File: rtl/squash_if.sv
// squash_if: pipeline flush broadcast
interface squash_if;
  logic valid;
  modport master(output valid);
  modport slave(input valid);
endinterface

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack; overflow overwrites the oldest entry
module bp_ras
  import branch_predictor_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  logic [63:0] push_addr,
  output logic [63:0] top,
  output logic        empty
);
  localparam int PTR_W = $clog2(NR_RAS_ENTRIES);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(NR_RAS_ENTRIES);
  logic [63:0] mem [NR_RAS_ENTRIES];
  logic [PTR_W-1:0] ptr, top_ptr;
  logic [PTR_W:0] count;
  assign top_ptr = ptr - PTR_W'(1);
  assign top = mem[top_ptr];
  assign empty = count == '0;
  // pointer/occupancy; pop+push together replaces the top in place
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      ptr <= '0;
      count <= '0;
    end else if (clear) begin
      ptr <= '0;
      count <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + PTR_W'(1);
      count <= count == FULL ? count : count + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      ptr <= top_ptr;
      count <= count - (PTR_W+1)'(1);
    end
  // return-address storage, no reset needed since count guards reads
  always_ff @(posedge clk)
    if (push && !clear) mem[pop ? top_ptr : ptr] <= push_addr;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal BHT + direct-mapped BTB predictor feeding the branch queue; optional RAS via BP_RAS_EN
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  id_t              in_id,
  input  ctrl_set_t        in_op,
  input  logic [63:0]      in_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  bq_push_if.master        bq_push_io,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  input  logic             upd_valid,
  input  logic [63:0]      upd_pc,
  input  ctrl_set_t        upd_op,
  input  logic             upd_taken,
  input  logic [63:0]      upd_target,
  squash_if.slave          squash_io
);
  bht_ctr_t bht [NR_BHT_ENTRIES];
  btb_entry_t btb [NR_BTB_ENTRIES];
  logic stage_v, squash, accept, fire, btb_hit, ras_hit;
  bp_t stage_bp, pred;
  logic [63:0] stage_pc, pc_imm, pc4, btb_tgt, ras_top;
  id_t stage_id;
  btb_entry_t btb_e;
  bht_ctr_t ctr, upd_old, upd_ctr;
  logic [BHT_IDX_W-1:0] upd_bht_idx;
  logic [BTB_IDX_W-1:0] upd_btb_idx;
  logic unused_ok;
  assign squash = squash_io.valid;
  assign in_ready = !stage_v || bq_push_io.ready;
  assign accept = in_valid && in_ready && !squash;
  assign bq_push_io.valid = stage_v && !squash;
  assign bq_push_io.bp = stage_bp;
  assign bq_push_io.pc = stage_pc;
  assign bq_push_io.id = stage_id;
  assign fire = bq_push_io.valid && bq_push_io.ready;
  assign redirect_valid = fire && stage_bp.taken;
  assign redirect_pc = stage_bp.pcnext;
  assign ctr = bht[in_pc[BHT_IDX_W+1:2]];
  assign btb_e = btb[in_pc[BTB_IDX_W+1:2]];
  assign btb_hit = btb_e.valid && btb_e.tag == in_pc[63:BTB_IDX_W+2];
  assign btb_tgt = {btb_e.target[63:1], 1'b0};
  assign pc_imm = in_pc + in_imm;
  assign pc4 = in_pc + 64'd4;
  assign pred.taken = !is_bxx(in_op) || ctr[1];
  assign pred.pcnext = in_op == OP_JALR ? (ras_hit ? ras_top : btb_hit ? btb_tgt : pc4) : pred.taken ? pc_imm : pc4;
  assign upd_bht_idx = upd_pc[BHT_IDX_W+1:2];
  assign upd_btb_idx = upd_pc[BTB_IDX_W+1:2];
  assign upd_old = bht[upd_bht_idx];
  assign upd_ctr = upd_taken ? (upd_old == 2'b11 ? upd_old : upd_old + 2'd1) : (upd_old == 2'b00 ? upd_old : upd_old - 2'd1);
`ifdef BP_RAS_EN
  logic ras_empty, is_call, is_ret;
  assign is_call = !is_bxx(in_op) && is_link(in_rd);
  assign is_ret = in_op == OP_JALR && is_link(in_rs1) && !is_link(in_rd);
  assign ras_hit = is_ret && !ras_empty;
  bp_ras u_ras (
    .clk(clk), .rstn(rstn), .clear(squash), .push(accept && is_call), .pop(accept && ras_hit),
    .push_addr(pc4), .top(ras_top), .empty(ras_empty)
  );
  assign unused_ok = ^{bq_push_io.bqid, upd_pc[1:0]};
`else
  assign ras_hit = 1'b0;
  assign ras_top = '0;
  assign unused_ok = ^{bq_push_io.bqid, upd_pc[1:0], in_rd, in_rs1};
`endif
  // single pipeline stage: squash wins, then refill, then drain on push
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      stage_v <= 1'b0;
      stage_bp <= '0;
      stage_pc <= '0;
      stage_id <= '0;
    end else begin
      stage_v <= squash ? 1'b0 : accept ? 1'b1 : fire ? 1'b0 : stage_v;
      if (accept) begin
        stage_bp <= pred;
        stage_pc <= in_pc;
        stage_id <= in_id;
      end
    end
  // bimodal counters trained by committed conditional branches
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < NR_BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_valid && is_bxx(upd_op)) begin
      bht[upd_bht_idx] <= upd_ctr;
    end
  // BTB filled by committed jumps, latest target wins
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < NR_BTB_ENTRIES; i++) btb[i] <= '0;
    end else if (upd_valid && !is_bxx(upd_op)) begin
      btb[upd_btb_idx] <= '{valid: 1'b1, tag: upd_pc[63:BTB_IDX_W+2], target: upd_target};
    end
endmodule
